jk_bank_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for an external bank of WIDTH JK flip-flops (jk_ff instances).
- Each requester issues a masked command: HOLD, RESET, SET or TOGGLE.
- The block drives j/k for exactly one cycle, waits for the bank to update, then returns the bank's new q to the granted requester.

---
 rtl/jk_arb_pkg.sv | 19 +
 rtl/jk_rr_grant.sv | 30 +++
 rtl/jk_bank_arbiter.sv | 123 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_arb_pkg.sv
// Shared constants for the JK bank arbiter: opcodes, FSM state encoding and requester ids.
package jk_arb_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/jk_rr_grant.sv
// Two-way round-robin grant; last_grant resets to B so A wins the first contention.
module jk_rr_grant
  import jk_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic valid_a_i,
  input  logic valid_b_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  logic last_q, last_d;

  assign grant_a_o = idle_i & valid_a_i & (~valid_b_i | (last_q == ID_B));
  assign grant_b_o = idle_i & valid_b_i & ~grant_a_o;

  always_comb begin
    last_d = last_q;
    if (grant_a_o)      last_d = ID_A;
    else if (grant_b_o) last_d = ID_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= ID_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin sequencer driving a bank of JK flip-flops with a fixed 4-cycle command period.
// Optional self-check of the bank response is enabled with macro JK_ARB_CHECK_EN.
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_a,
  input  logic [1:0]       req_op_a,
  input  logic [WIDTH-1:0] req_mask_a,
  output logic             req_ready_a,
  input  logic             req_valid_b,
  input  logic [1:0]       req_op_b,
  input  logic [WIDTH-1:0] req_mask_b,
  output logic             req_ready_b,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_q,
`ifdef JK_ARB_CHECK_EN
  output logic             resp_err,
`endif
  output logic             busy
);

  state_e           state_q;
  logic [WIDTH-1:0] j_q, k_q, resp_q_q;
  logic             id_q, resp_valid_q, resp_id_q;
  logic             gnt_a, gnt_b;
  logic [1:0]       op_d;
  logic [WIDTH-1:0] mask_d, j_d, k_d;

  // Ready is also held low while reset is asserted so every output reads 0 in reset.
  jk_rr_grant u_grant (
    .clk       (clk),
    .rst_n     (rst),
    .idle_i    ((state_q == ST_IDLE) & rst),
    .valid_a_i (req_valid_a),
    .valid_b_i (req_valid_b),
    .grant_a_o (gnt_a),
    .grant_b_o (gnt_b)
  );

  always_comb begin
    op_d   = gnt_b ? req_op_b   : req_op_a;
    mask_d = gnt_b ? req_mask_b : req_mask_a;
    j_d    = ((op_d == OP_SET)   || (op_d == OP_TOGGLE)) ? mask_d : '0;
    k_d    = ((op_d == OP_RESET) || (op_d == OP_TOGGLE)) ? mask_d : '0;
  end

`ifdef JK_ARB_CHECK_EN
  // exp_q holds the JK next-state of q_prev under the issued j/k, taken during ISSUE.
  logic [WIDTH-1:0] exp_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) exp_q <= (j_q & ~q_in) | (~k_q & q_in);
      if (state_q == ST_WAIT)  err_q <= (q_in != exp_q);
      else                     err_q <= 1'b0;
    end
  end

  assign resp_err = err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      j_q          <= '0;
      k_q          <= '0;
      id_q         <= ID_A;
      resp_q_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_a || gnt_b) begin
            j_q     <= j_d;
            k_q     <= k_d;
            id_q    <= gnt_b ? ID_B : ID_A;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          j_q     <= '0;
          k_q     <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          resp_q_q     <= q_in;
          resp_valid_q <= 1'b1;
          resp_id_q    <= id_q;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          resp_id_q    <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_a = gnt_a;
  assign req_ready_b = gnt_b;
  assign j_out       = j_q;
  assign k_out       = k_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_q      = resp_q_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter with a behavioural JK bank; build with JK_ARB_CHECK_EN for resp_err.
module tb_jk_bank_arbiter;

  localparam int W = 8;
  localparam logic [1:0] HOLD = 2'b00, RST_OP = 2'b01, SET = 2'b10, TOG = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic [1:0]   req_op_a = '0, req_op_b = '0;
  logic [W-1:0] req_mask_a = '0, req_mask_b = '0;
  logic         req_ready_a, req_ready_b;
  logic [W-1:0] j_out, k_out, resp_q;
  logic [W-1:0] bank_q = '0;
  logic         resp_valid, resp_id, busy;
`ifdef JK_ARB_CHECK_EN
  logic         resp_err;
`endif

  jk_bank_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_a(req_valid_a), .req_op_a(req_op_a), .req_mask_a(req_mask_a), .req_ready_a(req_ready_a),
    .req_valid_b(req_valid_b), .req_op_b(req_op_b), .req_mask_b(req_mask_b), .req_ready_b(req_ready_b),
    .j_out(j_out), .k_out(k_out), .q_in(bank_q),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_q(resp_q),
`ifdef JK_ARB_CHECK_EN
    .resp_err(resp_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural bank; fault_set0 makes bit 0 ignore SET.
  logic         bank_ld = 1'b0, fault_set0 = 1'b0;
  logic [W-1:0] bank_ld_val = '0;
  always @(posedge clk) begin
    if (bank_ld) bank_q <= bank_ld_val;
    else
      for (int i = 0; i < W; i++)
        case ({j_out[i], k_out[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= (fault_set0 && i == 0) ? bank_q[i] : 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
  end

  function automatic logic [W-1:0] apply(input logic [1:0] op, input logic [W-1:0] mask,
                                         input logic [W-1:0] q, input logic flt);
    logic [W-1:0] r = q;
    for (int i = 0; i < W; i++)
      if (mask[i])
        case (op)
          RST_OP:  r[i] = 1'b0;
          SET:     r[i] = (flt && i == 0) ? q[i] : 1'b1;
          TOG:     r[i] = ~q[i];
          default: r[i] = q[i];
        endcase
    return r;
  endfunction

  typedef struct { logic id; logic [W-1:0] q; logic err; int cyc; } exp_t;
  exp_t         sb[$];
  logic [W-1:0] model_q = '0, exp_j = '0, exp_k = '0;
  logic         iss_pend = 1'b0;

  // Monitor: check ISSUE j/k, pop responses, push expectations on acceptance.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] op;
    logic [W-1:0] m, nq;
    if (iss_pend) begin
      check_eq("iss_j", 32'(j_out), 32'(exp_j));
      check_eq("iss_k", 32'(k_out), 32'(exp_k));
      check_eq("iss_busy", 32'(busy), 32'd1);
      iss_pend = 1'b0;
    end
    if (resp_valid) begin
      if (sb.size() == 0) check_eq("resp_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check_eq("resp_id", 32'(resp_id), 32'(e.id));
        check_eq("resp_q", 32'(resp_q), 32'(e.q));
        check_eq("resp_latency", 32'(cyc - e.cyc), 32'd3);
`ifdef JK_ARB_CHECK_EN
        check_eq("resp_err", 32'(resp_err), 32'(e.err));
`endif
      end
    end
    if (req_ready_a && req_ready_b) check_eq("ready_both", 32'd1, 32'd0);
    if (req_ready_a || req_ready_b) begin
      op = req_ready_b ? req_op_b : req_op_a;
      m  = req_ready_b ? req_mask_b : req_mask_a;
      nq = apply(op, m, model_q, fault_set0);
      e.id = req_ready_b; e.q = nq; e.cyc = cyc;
      e.err = (nq != apply(op, m, model_q, 1'b0));
      sb.push_back(e);
      model_q = nq;
      exp_j = (op == SET || op == TOG) ? m : '0;
      exp_k = (op == RST_OP || op == TOG) ? m : '0;
      iss_pend = 1'b1;
    end
  end

  task automatic load_bank(input logic [W-1:0] v);
    @(posedge clk); #1; bank_ld = 1'b1; bank_ld_val = v;
    @(posedge clk); #1; bank_ld = 1'b0; model_q = v;
  endtask

  task automatic send(input logic who, input logic [1:0] op, input logic [W-1:0] mask);
    logic got = 1'b0;
    @(posedge clk); #1;
    if (who) begin req_valid_b = 1'b1; req_op_b = op; req_mask_b = mask; end
    else     begin req_valid_a = 1'b1; req_op_a = op; req_mask_a = mask; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = who ? req_ready_b : req_ready_a;
    end
    check_eq("accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic got;
    // Reset with random requester activity
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid_a = 1'($urandom); req_valid_b = 1'($urandom);
      req_op_a = 2'($urandom); req_op_b = 2'($urandom);
      req_mask_a = 8'($urandom); req_mask_b = 8'($urandom);
      @(negedge clk);
      check_eq("rst_ready_a", 32'(req_ready_a), 32'd0);
      check_eq("rst_ready_b", 32'(req_ready_b), 32'd0);
      check_eq("rst_j", 32'(j_out), 32'd0);
      check_eq("rst_k", 32'(k_out), 32'd0);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_resp_id", 32'(resp_id), 32'd0);
      check_eq("rst_resp_q", 32'(resp_q), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
    end
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("idle_ready", 32'(req_ready_a | req_ready_b), 32'd0);
      check_eq("idle_resp", 32'(resp_valid), 32'd0);
    end

    // Single A command
    load_bank(8'h00);
    send(1'b0, SET, 8'h0F);

    // Contention right after a reset: A,B,A,B
    load_bank(8'h00);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    req_op_a = TOG; req_mask_a = 8'h0F; req_op_b = SET; req_mask_b = 8'hF0;
    req_valid_a = 1'b1; req_valid_b = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        got = req_ready_a | req_ready_b;
      end
      check_eq("rr_grant_seen", 32'(got), 32'd1);
      check_eq("rr_order", 32'(req_ready_b), 32'(g % 2));
      @(posedge clk); #1;
    end
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("rr_drain", 32'(sb.size()), 32'd0);

    // Decode sequence
    load_bank(8'h00);
    send(1'b0, TOG, 8'hFF);
    send(1'b1, RST_OP, 8'hF0);
    send(1'b0, TOG, 8'hFF);
    send(1'b1, HOLD, 8'hFF);
    send(1'b0, TOG, 8'h00);

    // Reset during ISSUE
    load_bank(8'h00);
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_op_a = SET; req_mask_a = 8'hFF;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = req_ready_a;
    end
    check_eq("mid_accept", 32'(got), 32'd1);
    @(posedge clk); #1 req_valid_a = 1'b0;
    #1 check_eq("mid_issue_j", 32'(j_out), 32'hFF);
    rst = 1'b0;
    sb.delete(); iss_pend = 1'b0; model_q = 8'h00;
    #1;
    check_eq("mid_async_j", 32'(j_out), 32'd0);
    check_eq("mid_async_k", 32'(k_out), 32'd0);
    check_eq("mid_async_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    send(1'b0, TOG, 8'h3C);

`ifdef JK_ARB_CHECK_EN
    load_bank(8'h00);
    fault_set0 = 1'b1;
    send(1'b0, SET, 8'h01);
    fault_set0 = 1'b0;
    send(1'b0, SET, 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
